// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: FIFO controller around an external simple dual-port BRAM.
// Credit-gated reads feed a small registered output buffer.
module bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512,
  parameter int LATENCY    = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  flush,
  output logic [AW+1:0]         level,
  output logic [AW-1:0]         ram_addra,
  output logic                  ram_wea,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic [AW-1:0]         ram_addrb,
  output logic                  ram_enb,
  output logic                  ram_regceb,
  output logic                  ram_rstb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  localparam int OBN = LATENCY + 1;
  localparam int OW  = (OBN > 1) ? $clog2(OBN) : 1;
  localparam int CW  = $clog2(LATENCY + 2);

  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [CW:0]   CRED     = (CW+1)'(LATENCY + 1);
  localparam logic [OW-1:0] OB_LAST  = OW'(OBN - 1);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           ram_occ;
  logic [LATENCY-1:0]    tag;
  logic [DATA_WIDTH-1:0] ob_mem [OBN];
  logic [OW-1:0]         ob_head;
  logic [OW-1:0]         ob_tail;
  logic [CW-1:0]         ob_cnt;
  logic [CW-1:0]         inflight;
  logic [CW:0]           cred_used;
  logic                  push;
  logic                  issue;
  logic                  cap;
  logic                  pop;

  function automatic logic [OW-1:0] ob_inc(input logic [OW-1:0] p);
    return (p == OB_LAST) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = rst_n && (ram_occ < OCC_FULL) && !flush;
  assign push      = in_valid && in_ready;
  assign out_valid = (ob_cnt != '0);
  assign pop       = out_valid && out_ready && !flush;
  assign cap       = tag[LATENCY-1];
  assign out_data  = ob_mem[ob_head];

  // Count reads issued but not yet captured.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + CW'(tag[i]);
    end
  end

  // A slot being popped this cycle is already free for a new read.
  assign cred_used = {1'b0, inflight} + {1'b0, ob_cnt}
                   - {{CW{1'b0}}, pop};
  assign issue = (ram_occ != '0) && !flush && (cred_used < CRED);

  assign level = {1'b0, ram_occ} + (AW+2)'(inflight)
               + (AW+2)'(ob_cnt);

  assign ram_wea    = push;
  assign ram_addra  = wr_ptr;
  assign ram_dina   = in_data;
  assign ram_enb    = issue;
  assign ram_addrb  = rd_ptr;
  assign ram_regceb = 1'b1;
  assign ram_rstb   = 1'b0;

  // Pointers, occupancy, read tags and output-buffer bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_occ <= '0;
      tag     <= '0;
      ob_cnt  <= '0;
      ob_head <= '0;
      ob_tail <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_occ <= '0;
      tag     <= '0;
      ob_cnt  <= '0;
      ob_head <= '0;
      ob_tail <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      ram_occ <= ram_occ + (AW+1)'(push) - (AW+1)'(issue);
      tag     <= (tag << 1) | LATENCY'(issue);
      ob_cnt  <= ob_cnt + CW'(cap) - CW'(pop);
      if (cap) ob_tail <= ob_inc(ob_tail);
      if (pop) ob_head <= ob_inc(ob_head);
    end
  end

  // Output-buffer storage; captures are dropped during a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBN; i++) begin
        ob_mem[i] <= '0;
      end
    end else if (cap && !flush) begin
      ob_mem[ob_tail] <= ram_doutb;
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: vector table, corner sequences and a
// queue-model random run for bram_fifo_ctrl.
module tb_bram_fifo_ctrl;

  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int LAT = 2;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
  logic [AW+1:0] level;
  logic [AW-1:0] ram_addra;
  logic          ram_wea;
  logic [DW-1:0] ram_dina;
  logic [AW-1:0] ram_addrb;
  logic          ram_enb;
  logic          ram_regceb;
  logic          ram_rstb;
  logic [DW-1:0] ram_doutb;

  bram_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .flush(flush),
    .level(level),
    .ram_addra(ram_addra),
    .ram_wea(ram_wea),
    .ram_dina(ram_dina),
    .ram_addrb(ram_addrb),
    .ram_enb(ram_enb),
    .ram_regceb(ram_regceb),
    .ram_rstb(ram_rstb),
    .ram_doutb(ram_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage (HIGH_PERFORMANCE) BRAM model
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_q;
  logic [DW-1:0] ram_q2;

  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_q <= mem[ram_addrb];
    if (ram_rstb) ram_q2 <= '0;
    else if (ram_regceb) ram_q2 <= ram_q;
  end
  assign ram_doutb = ram_q2;

  int tests;
  int fails;
  int n_push;
  int n_pop;
  int ovf;
  logic g_ov;
  logic [DW-1:0] mq[$];

  // Capture into a full output buffer without a pop is an overflow
  always @(negedge clk) begin
    if (rst_n && !flush && dut.cap && !dut.pop && dut.ob_cnt == 2'd3)
      ovf++;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus; the queue model tracks contents.
  task automatic cyc(input logic iv, input logic [DW-1:0] d,
                     input logic ordy, input logic fl);
    logic pa;
    logic pp;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    flush = fl;
    @(negedge clk);
    chk("level", 64'(level), 64'(mq.size()));
    if (fl) chk("flush_in_ready", 64'(in_ready), 64'd0);
    g_ov = out_valid;
    pa = in_valid && in_ready;
    pp = out_valid && out_ready && !flush;
    if (pp) begin
      if (mq.size() == 0) begin
        chk("pop_empty", 64'(out_data), 64'hffff_ffff);
      end else begin
        chk("out_data", 64'(out_data), 64'(mq.pop_front()));
      end
      n_pop++;
    end
    if (pa) begin
      mq.push_back(d);
      n_push++;
    end
    if (fl) mq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (mq.size() != 0 && k < 300) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      k++;
    end
    chk("drain_done", 64'(mq.size()), 64'd0);
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          ov;
    logic [DW-1:0] od;
    logic [AW+1:0] lv;
    logic          enb;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] d,
                              input logic ordy, input logic ov,
                              input logic [DW-1:0] od,
                              input logic [AW+1:0] lv,
                              input logic enb);
    vec_t v;
    v.iv = iv;
    v.d = d;
    v.ordy = ordy;
    v.ov = ov;
    v.od = od;
    v.lv = lv;
    v.enb = enb;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    int base;
    int k;
    int started;
    int bubbles;
    int pcyc;
    int first_ov;
    tests = 0;
    fails = 0;
    n_push = 0;
    n_pop = 0;
    ovf = 0;
    g_ov = 1'b0;

    tbl[0]  = mk(1, 16'h00a5, 1, 0, 16'h0000, 0, 0);
    tbl[1]  = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 1);
    tbl[2]  = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 0);
    tbl[3]  = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 0);
    tbl[4]  = mk(0, 16'h0000, 1, 1, 16'h00a5, 1, 0);
    tbl[5]  = mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0);
    tbl[6]  = mk(1, 16'h0011, 0, 0, 16'h0000, 0, 0);
    tbl[7]  = mk(1, 16'h0022, 0, 0, 16'h0000, 1, 1);
    tbl[8]  = mk(0, 16'h0000, 0, 0, 16'h0000, 2, 1);
    tbl[9]  = mk(0, 16'h0000, 0, 0, 16'h0000, 2, 0);
    tbl[10] = mk(0, 16'h0000, 0, 1, 16'h0011, 2, 0);
    tbl[11] = mk(0, 16'h0000, 1, 1, 16'h0011, 2, 0);
    tbl[12] = mk(0, 16'h0000, 1, 1, 16'h0022, 1, 0);
    tbl[13] = mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0);

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    flush = 1'b0;

    // Outputs held inactive during reset, even with in_valid high
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_wea", 64'(ram_wea), 64'd0);
    chk("rst_enb", 64'(ram_enb), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Single-item latency and two-item ordering vectors
    for (int i = 0; i < 14; i++) begin
      in_valid = tbl[i].iv;
      in_data = tbl[i].d;
      out_ready = tbl[i].ordy;
      flush = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid),
          64'(tbl[i].ov));
      if (tbl[i].ov)
        chk($sformatf("vec%0d_out_data", i), 64'(out_data),
            64'(tbl[i].od));
      chk($sformatf("vec%0d_level", i), 64'(level), 64'(tbl[i].lv));
      chk($sformatf("vec%0d_enb", i), 64'(ram_enb), 64'(tbl[i].enb));
      @(posedge clk);
      #1;
    end

    // Fill with out_ready low: DEPTH + LATENCY + 1 items fit
    base = n_push;
    for (int i = 0; i < 20; i++)
      cyc(1'b1, DW'(n_push - base), 1'b0, 1'b0);
    chk("fill_accepted", 64'(n_push - base), 64'd11);
    in_valid = 1'b1;
    #1;
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_level", 64'(level), 64'd11);
    in_valid = 1'b0;
    drain();

    // Streaming: 3*DEPTH items, no bubbles once output starts
    base = n_push;
    k = 0;
    started = 0;
    bubbles = 0;
    pcyc = 0;
    first_ov = -1;
    while ((n_pop - base) < 24 && k < 200) begin
      if ((n_push - base) < 24) pcyc++;
      cyc((n_push - base) < 24, DW'(16'h100 + n_push - base),
          1'b1, 1'b0);
      if (g_ov && started == 0) begin
        started = 1;
        first_ov = k;
      end else if (started != 0 && !g_ov) begin
        bubbles++;
      end
      k++;
    end
    chk("stream_done", 64'(n_pop - base), 64'd24);
    chk("stream_push_cycles", 64'(pcyc), 64'd24);
    chk("stream_first_ov", 64'(first_ov), 64'd4);
    chk("stream_bubbles", 64'(bubbles), 64'd0);

    // Random valid/ready, 1000 items
    base = n_push;
    k = 0;
    while ((n_push - base) < 1000 && k < 20000) begin
      cyc($urandom_range(0, 99) < 70,
          DW'({(n_push - base) & 1023, 6'($urandom)}),
          1'($urandom), 1'b0);
      k++;
    end
    chk("rand_pushed", 64'(n_push - base), 64'd1000);
    drain();
    chk("rand_popped", 64'(n_pop - base), 64'd1000);

    // Flush while reads are in flight
    for (int i = 0; i < 10; i++)
      cyc(1'b1, DW'(16'h200 + i), (i < 3) ? 1'b0 : 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("flush_out_valid", 64'(g_ov), 64'd0);
    end
    cyc(1'b1, 16'h0077, 1'b1, 1'b0);
    drain();

    // Short reset pulse mid-stream
    for (int i = 0; i < 6; i++)
      cyc(1'b1, DW'(16'h300 + i), 1'b1, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("pulse_out_valid", 64'(out_valid), 64'd0);
    chk("pulse_level", 64'(level), 64'd0);
    chk("pulse_in_ready", 64'(in_ready), 64'd0);
    #1;
    rst_n = 1'b1;
    mq.delete();
    @(posedge clk);
    #1;
    base = n_pop;
    cyc(1'b1, 16'hbeef, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, '0, 1'b1, 1'b0);
    chk("pulse_pops", 64'(n_pop - base), 64'd1);
    chk("pulse_tail_ov", 64'(g_ov), 64'd0);

    chk("ob_overflow", 64'(ovf), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
